// File: rtl/bcd_if.sv
// Operand/result bundle for one registered BCD digit adder.
interface bcd_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       Ci;
  logic [3:0] S;
  logic       Cb;
  logic       Err;

  // Driver side: supplies operands, observes the registered result.
  modport master (
    output A,
    output B,
    output Ci,
    input  S,
    input  Cb,
    input  Err
  );

  // Adder side: consumes operands, returns the registered result.
  modport slave (
    input  A,
    input  B,
    input  Ci,
    output S,
    output Cb,
    output Err
  );
endinterface

// File: rtl/bcd.sv
// Single-digit registered BCD adder: S/Cb = decimal units/carry of A+B+Ci,
// with Err flagging non-BCD operands. One-cycle latency, one add per cycle.
module bcd (
  input  logic  clk,
  input  logic  rst_n,
  bcd_if.slave  bus
);

  logic [4:0] sum;
  logic [4:0] sum_adj;
  logic       invalid;
  logic [3:0] s_d, s_q;
  logic       cb_d, cb_q;
  logic       err_d, err_q;

  // Binary sum, decimal correction and operand validation.
  always_comb begin
    sum     = {1'b0, bus.A} + {1'b0, bus.B} + {4'd0, bus.Ci};
    // +6 skips the six unused codes; the 5-bit compare also catches 16..19.
    sum_adj = sum + 5'd6;
    invalid = (bus.A > 4'd9) || (bus.B > 4'd9);
    s_d     = sum[3:0];
    cb_d    = 1'b0;
    err_d   = 1'b0;
    if (invalid) begin
      s_d   = 4'd0;
      cb_d  = 1'b0;
      err_d = 1'b1;
    end else if (sum > 5'd9) begin
      s_d   = sum_adj[3:0];
      cb_d  = 1'b1;
    end
  end

  // Result register; async reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= 4'd0;
      cb_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      cb_q  <= cb_d;
      err_q <= err_d;
    end
  end

  assign bus.S   = s_q;
  assign bus.Cb  = cb_q;
  assign bus.Err = err_q;

endmodule

// File: tb/tb_bcd.sv
// Self-checking bench for bcd: decimal reference model checked every cycle,
// plus literal expectations for the directed cases.
module tb_bcd;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bcd_if bus ();

  bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal arithmetic on the inputs sampled at each edge.
  logic [3:0] exp_s;
  logic       exp_cb;
  logic       exp_err;

  always @(posedge clk or negedge rst_n) begin
    int total;
    if (!rst_n) begin
      exp_s   <= 4'd0;
      exp_cb  <= 1'b0;
      exp_err <= 1'b0;
    end else if (bus.A > 9 || bus.B > 9) begin
      exp_s   <= 4'd0;
      exp_cb  <= 1'b0;
      exp_err <= 1'b1;
    end else begin
      total   = int'(bus.A) + int'(bus.B) + int'(bus.Ci);
      exp_s   <= 4'(total % 10);
      exp_cb  <= (total / 10) != 0;
      exp_err <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got {Err,Cb,S}=%b_%b_%0d expected %b_%b_%0d at %0t", name,
               got[5], got[4], got[3:0], want[5], want[4], want[3:0], $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model", {bus.Err, bus.Cb, bus.S}, {exp_err, exp_cb, exp_s});
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    bus.A  = a;
    bus.B  = b;
    bus.Ci = ci;
  endtask

  // Apply one vector and check the literal result one cycle later.
  task automatic vec(input string name, input logic [3:0] a, input logic [3:0] b,
                     input logic ci, input logic err, input logic cb, input logic [3:0] s);
    drive(a, b, ci);
    @(posedge clk);
    #1;
    check(name, {bus.Err, bus.Cb, bus.S}, {err, cb, s});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.A    = 4'd7;
    bus.B    = 4'd8;
    bus.Ci   = 1'b1;

    // Outputs stay zero while reset is held, despite clocking.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", {bus.Err, bus.Cb, bus.S}, 6'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    vec("carry_5_8",     4'd5,  4'd8, 1'b0, 1'b0, 1'b1, 4'd3);
    vec("nocarry_3_4",   4'd3,  4'd4, 1'b0, 1'b0, 1'b0, 4'd7);
    vec("max_9_9",       4'd9,  4'd9, 1'b0, 1'b0, 1'b1, 4'd8);
    vec("max_9_9_ci",    4'd9,  4'd9, 1'b1, 1'b0, 1'b1, 4'd9);
    vec("edge_4_5",      4'd4,  4'd5, 1'b0, 1'b0, 1'b0, 4'd9);
    vec("edge_4_5_ci",   4'd4,  4'd5, 1'b1, 1'b0, 1'b1, 4'd0);
    vec("zero",          4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    vec("invalid_a10",   4'd10, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0);
    vec("after_invalid", 4'd2,  4'd3, 1'b0, 1'b0, 1'b0, 4'd5);
    vec("invalid_b15",   4'd7,  4'd15, 1'b1, 1'b1, 1'b0, 4'd0);
    vec("invalid_both",  4'd12, 4'd11, 1'b1, 1'b1, 1'b0, 4'd0);
    vec("ci_only_0_0",   4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 4'd1);

    // Asynchronous reset mid-operation clears outputs before any edge.
    vec("pre_async",     4'd8,  4'd7, 1'b1, 1'b0, 1'b1, 4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {bus.Err, bus.Cb, bus.S}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("post_reset",    4'd6,  4'd6, 1'b0, 1'b0, 1'b1, 4'd2);

    // All 200 legal combinations back to back; the model checks each cycle.
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive(4'(a), 4'(b), c[0]);
        end
      end
    end
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd.md
# bcd

Single-digit registered BCD adder. Adds two packed-BCD digits and a carry-in, producing a corrected BCD sum digit and a decimal carry-out. It is the per-digit building block for multi-digit decimal adders: chain `Cb` of one instance into `Ci` of the next-higher digit's instance. An invalid-digit flag reports non-BCD operands.

## Interface
- No parameters. Digit width is fixed at 4 bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `A`  input  4  BCD operand digit, legal range 0–9.
- `B`  input  4  BCD operand digit, legal range 0–9.
- `Ci`  input  1  decimal carry-in.
- `S`  output  4  registered BCD sum digit, 0–9.
- `Cb`  output  1  registered decimal carry-out (overflow past 9).
- `Err`  output  1  registered flag: 1 when A or B was > 9.

## Operation
- Binary sum: `sum = A + B + Ci`, computed 5 bits wide (range 0–19 for legal inputs).
- Decimal correction:
  - If `sum > 9`: `S = (sum + 6)[3:0]` and `Cb = 1`. Equivalently, `S = sum - 10`.
  - Otherwise: `S = sum[3:0]` and `Cb = 0`.
- Correction is decided on the full 5-bit sum, so 16–19 (binary carry set) are corrected just like 10–15.
- Invalid operand (`A > 9` or `B > 9`): `Err = 1`, and `S` and `Cb` are forced to 0 for that result.
- Valid operands: `Err = 0`.
- `Ci` takes any value 0/1 with no restriction; `Ci` alone never sets `Err`.
- Pure datapath: no state machine and no handshake. Every cycle samples the inputs and produces a result.

## Timing
- All outputs are registered and update on the rising edge of `clk`.
- Latency is 1 cycle: inputs present before edge N appear on `S`, `Cb` and `Err` after edge N and hold until edge N+1.
- Throughput is one addition per cycle. Back-to-back operand changes are each reflected one cycle later, with no bubbles.
- Reset: `rst_n` low immediately (asynchronously) forces `S = 0`, `Cb = 0` and `Err = 0`, independent of `clk`.
- Outputs hold 0 while `rst_n` is low.
- The first result after release is computed from inputs sampled at the first rising edge with `rst_n` high.
- Reset asserted mid-stream discards the pending result. There is no recovery of lost data.
- Chaining: the combinational path from `A`/`B`/`Ci` to the register input must fit in one cycle. Instance-to-instance ripple goes through registered `Cb`, so a multi-digit chain adds one cycle of latency per digit unless the integrator aligns stages.
- Inputs are assumed stable around the clock edge (standard setup/hold). No internal synchronizers.

## Test plan
- Reset: hold `rst_n = 0` with A=7, B=8, Ci=1 and toggle `clk` → S=0, Cb=0, Err=0 throughout. Assert `rst_n` low mid-operation → outputs clear immediately, without waiting for a clock edge.
- Carry case: A=5, B=8, Ci=0 → one cycle later S=3, Cb=1, Err=0. A=3, B=4, Ci=0 → S=7, Cb=0, Err=0.
- Maximum case: A=9, B=9, Ci=0 → S=8, Cb=1. A=9, B=9, Ci=1 → S=9, Cb=1.
- Boundary at 9/10: A=4, B=5, Ci=0 → S=9, Cb=0. A=4, B=5, Ci=1 → S=0, Cb=1. A=0, B=0, Ci=0 → S=0, Cb=0.
- Invalid operand: A=10, B=3, Ci=0 → S=0, Cb=0, Err=1. Next cycle A=2, B=3 → S=5, Cb=0, Err=0.
- Exhaustive/pipelined: all 200 legal (A, B, Ci) combinations applied back to back, one per cycle. Each output must equal the decimal reference of the previous cycle's inputs: {Cb,S} = tens/units of A+B+Ci.
